fetch_controller: RTL



---
 rtl/upower_fetch_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 50 +++++
 rtl/fetch_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/upower_fetch_pkg.sv
// Shared types for the uPower instruction fetch path: controller states,
// buffered fetch entries and the buffer depth.
package upower_fetch_pkg;

  localparam int FETCH_BUF_DEPTH = 2;
  localparam int FETCH_PC_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between memory and decode.
// Flush empties the buffer and wins over push; a same-cycle pop is simply absorbed.
module fetch_buffer
  import upower_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop_ok;
  logic         push_ok;

  // Guard against pops on empty and pushes into a full buffer without a pop.
  assign pop_ok  = pop & (count != 2'd0);
  assign push_ok = push & ((count < 2'd2) | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: walks the program counter through instruction memory,
// buffers results for decode, and handles redirects and end of program.
module fetch_controller
  import upower_fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_INSTR = 6,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] program_counter,
  input  logic [31:0]       instruction,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output fetch_state_t      dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(NUM_INSTR - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q;
  logic              push, pop, flush;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      wr_entry;

  // Decode handshake: an instruction transfers on any cycle where if_valid and
  // if_ready are both high; if_valid/if_instr/if_pc stay stable until then.
  assign pop = if_valid & if_ready;

  assign wr_entry.pc    = FETCH_PC_W'(pc_q);
  assign wr_entry.instr = instruction;

  fetch_buffer u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH, DRAIN: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = (redirect_pc > LAST_PC) ? HALT : FETCH;
        end else if (state_q == FETCH) begin
          if ((count < 2'd2) || pop) begin
            push = 1'b1;
            if (pc_q == LAST_PC) state_d = DRAIN;
            else                 pc_d    = pc_q + ADDR_W'(1);
          end
        end else if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign program_counter = pc_q;
  assign if_valid        = (count != 2'd0);
  assign if_instr        = head.instr;
  assign if_pc           = ADDR_W'(head.pc);
  assign halted          = halted_q;
  assign dbg_state       = state_q;

endmodule
